nap_timer: RTL and testbench
============================

NAP_TIMER -- requirements
Module: nap_timer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: clocks button must be stable before its debounced value changes.
REQ-002 Parameter SNOOZE_LEN, default 5: ticks reloaded on a snooze.
REQ-003 Parameter MAX_SNOOZE, default 3: snoozes allowed per nap.
REQ-004 Parameter RING_TIMEOUT, default 60: ticks in RING before automatic stop.
REQ-005 reset  input  1  asynchronous, active-low.
REQ-006 clock  input  1  rising-edge clock.
REQ-007 tick  input  1  one-cycle time-base enable (nominally 1 Hz).
REQ-008 arm  input  1  request to begin a nap.
REQ-009 cancel  input  1  abort the current nap.
REQ-010 button  input  1  raw, asynchronous user button, active-high.
REQ-011 nap_len  input  8  nap length in ticks, sampled on arm.
REQ-012 start  output  1  one-cycle pulse that starts the alarm light sequencer.
REQ-013 stop  output  1  one-cycle pulse that returns the alarm light sequencer to its wait state.
REQ-014 busy  output  1  high in any state except IDLE.
REQ-015 ringing  output  1  high in RING.
REQ-016 remaining  output  8  ticks left in the current countdown.
REQ-017 snooze_cnt  output  2  snoozes used this nap (SNOOZE_EN only; otherwise tied 0).

Function
REQ-018 FSM states: IDLE, COUNT, RING; all outputs registered.
REQ-019 In IDLE, arm=1 with nap_len!=0 loads remaining=nap_len, clears snooze_cnt, and enters COUNT next cycle.
REQ-020 In IDLE, arm=1 with nap_len==0 pulses start next cycle and enters RING.
REQ-021 In COUNT, each tick decrements remaining by 1.
REQ-022 In COUNT, a tick with remaining==1 sets remaining=0, pulses start, and enters RING in the same clock.
REQ-023 arm SHALL be ignored while busy=1.
REQ-024 In RING, a ring-timeout counter increments on tick and is cleared on RING entry.
REQ-025 In RING, when the ring-timeout counter reaches RING_TIMEOUT: pulse stop, enter IDLE.
REQ-026 In RING, a debounced button rising edge (btn_rise) pulses stop and enters IDLE, unless REQ-036 applies.
REQ-027 cancel=1 in COUNT: enter IDLE, remaining=0, no start or stop pulse.
REQ-028 cancel=1 in RING: pulse stop, enter IDLE.
REQ-029 Priority when events coincide: cancel > btn_rise > ring timeout > tick.
REQ-030 start and stop SHALL never be high in the same cycle; each SHALL be high for exactly one clock per event.
REQ-031 Button path: 2-flop synchronizer, then a counter that requires DEBOUNCE_CYCLES consecutive equal samples before updating the debounced level.
REQ-032 btn_rise is a one-cycle pulse on a debounced 0->1 transition; a button already held on RING entry produces no btn_rise until it is released and pressed again.

Reset
REQ-033 reset low SHALL asynchronously force: state=IDLE, start=0, stop=0, busy=0, ringing=0, remaining=0, snooze_cnt=0, debounced level=0, all counters=0.
REQ-034 Reset mid-nap SHALL produce no start or stop pulse; the alarm's own reset returns it to its wait state.

Configuration
REQ-035 Macro NAP_TIMER_SNOOZE_EN compiles the snooze feature in.
REQ-036 With NAP_TIMER_SNOOZE_EN, btn_rise in RING with snooze_cnt<MAX_SNOOZE: pulse stop, set remaining=SNOOZE_LEN, increment snooze_cnt, enter COUNT; with snooze_cnt==MAX_SNOOZE the press dismisses per REQ-026.
REQ-037 Without NAP_TIMER_SNOOZE_EN: every btn_rise in RING dismisses; snooze_cnt tied to 0; no snooze logic is synthesized.

Structure
REQ-038 Package nap_pkg holds the state enum typedef and the default parameter constants.
REQ-039 Debounce logic lives in sub-module nap_debounce (ports: reset, clock, raw, level, rise).

Verification
REQ-040 nap_len=3, arm, ticks every 10 clocks -> remaining 3,2,1,0; start pulses once on the third tick; ringing=1.
REQ-041 RING, button held high for 2 clocks (DEBOUNCE_CYCLES=4) -> no stop; held 6 clocks -> exactly one stop pulse and IDLE.
REQ-042 RING, no button for 60 ticks -> stop pulses on the 60th tick; busy=0.
REQ-043 COUNT remaining=2, cancel coincident with a tick -> IDLE, remaining=0, no start/stop; RING with cancel and btn_rise coincident -> a single stop pulse.
REQ-044 SNOOZE_EN: three presses -> three stop pulses, each followed by a 5-tick recount and start; snooze_cnt=3; fourth press -> stop and IDLE.
REQ-045 reset asserted mid-COUNT with remaining=7 -> all outputs 0 immediately; arm after reset release behaves per REQ-019.

Source files
------------

// File: rtl/nap_pkg.sv
// Shared types and default configuration for the nap timer.
package nap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_RING  = 2'd2
  } nap_state_t;

  localparam int unsigned NAP_DEBOUNCE_CYCLES = 4;
  localparam int unsigned NAP_SNOOZE_LEN      = 5;
  localparam int unsigned NAP_MAX_SNOOZE      = 3;
  localparam int unsigned NAP_RING_TIMEOUT    = 60;
  localparam int unsigned NAP_LEN_W           = 8;
  localparam int unsigned NAP_SNOOZE_W        = 2;

endpackage

// File: rtl/nap_debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter, rising-edge pulse.
module nap_debounce
  import nap_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = NAP_DEBOUNCE_CYCLES
) (
  input  logic reset,
  input  logic clock,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES samples in a row.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      rise <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        cnt   <= '0;
        level <= sync2;
        rise  <= sync2;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/nap_timer.sv
// Nap countdown timer driving an alarm light sequencer via start/stop pulses.
// Optional snooze support is compiled in with NAP_TIMER_SNOOZE_EN.
module nap_timer
  import nap_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = NAP_DEBOUNCE_CYCLES,
  parameter int unsigned SNOOZE_LEN      = NAP_SNOOZE_LEN,
  parameter int unsigned MAX_SNOOZE      = NAP_MAX_SNOOZE,
  parameter int unsigned RING_TIMEOUT    = NAP_RING_TIMEOUT
) (
  input  logic                    reset,
  input  logic                    clock,
  input  logic                    tick,
  input  logic                    arm,
  input  logic                    cancel,
  input  logic                    button,
  input  logic [NAP_LEN_W-1:0]    nap_len,
  output logic                    start,
  output logic                    stop,
  output logic                    busy,
  output logic                    ringing,
  output logic [NAP_LEN_W-1:0]    remaining,
  output logic [NAP_SNOOZE_W-1:0] snooze_cnt
);

  localparam int unsigned RING_W = $clog2(RING_TIMEOUT + 1);

  // Reject configurations the counters cannot represent.
  if (MAX_SNOOZE > 3 || SNOOZE_LEN == 0 || SNOOZE_LEN > 255 || RING_TIMEOUT == 0) begin : g_cfg_check
    $error("nap_timer: unsupported SNOOZE_LEN/MAX_SNOOZE/RING_TIMEOUT");
  end

  nap_state_t            state;
  nap_state_t            state_n;
  logic                  start_n;
  logic                  stop_n;
  logic [NAP_LEN_W-1:0]  remaining_n;
  logic [RING_W-1:0]     ring_cnt;
  logic [RING_W-1:0]     ring_cnt_n;
  logic [NAP_SNOOZE_W-1:0] snooze_n;
  logic                  btn_level;
  logic                  btn_rise;
  logic                  btn_press;

  nap_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .reset(reset),
    .clock(clock),
    .raw  (button),
    .level(btn_level),
    .rise (btn_rise)
  );

  assign btn_press = btn_rise & btn_level;

  // Next-state and next-output decode; priority cancel > press > timeout > tick.
  always_comb begin
    state_n     = state;
    start_n     = 1'b0;
    stop_n      = 1'b0;
    remaining_n = remaining;
    ring_cnt_n  = ring_cnt;
    snooze_n    = snooze_cnt;
    case (state)
      ST_IDLE: begin
        if (arm) begin
          snooze_n   = '0;
          ring_cnt_n = '0;
          if (nap_len != '0) begin
            remaining_n = nap_len;
            state_n     = ST_COUNT;
          end else begin
            remaining_n = '0;
            start_n     = 1'b1;
            state_n     = ST_RING;
          end
        end
      end
      ST_COUNT: begin
        if (cancel) begin
          remaining_n = '0;
          state_n     = ST_IDLE;
        end else if (tick) begin
          if (remaining <= NAP_LEN_W'(1)) begin
            remaining_n = '0;
            ring_cnt_n  = '0;
            start_n     = 1'b1;
            state_n     = ST_RING;
          end else begin
            remaining_n = remaining - NAP_LEN_W'(1);
          end
        end
      end
      ST_RING: begin
        if (cancel) begin
          stop_n  = 1'b1;
          state_n = ST_IDLE;
        end else if (btn_press) begin
          stop_n  = 1'b1;
          state_n = ST_IDLE;
`ifdef NAP_TIMER_SNOOZE_EN
          if (snooze_cnt < NAP_SNOOZE_W'(MAX_SNOOZE)) begin
            snooze_n    = snooze_cnt + NAP_SNOOZE_W'(1);
            remaining_n = NAP_LEN_W'(SNOOZE_LEN);
            state_n     = ST_COUNT;
          end
`endif
        end else if (tick) begin
          if (ring_cnt == RING_W'(RING_TIMEOUT - 1)) begin
            ring_cnt_n = '0;
            stop_n     = 1'b1;
            state_n    = ST_IDLE;
          end else begin
            ring_cnt_n = ring_cnt + RING_W'(1);
          end
        end
      end
      default: begin
        state_n     = ST_IDLE;
        remaining_n = '0;
      end
    endcase
  end

  // State register with all registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      start     <= 1'b0;
      stop      <= 1'b0;
      busy      <= 1'b0;
      ringing   <= 1'b0;
      remaining <= '0;
      ring_cnt  <= '0;
    end else begin
      state     <= state_n;
      start     <= start_n;
      stop      <= stop_n;
      busy      <= (state_n != ST_IDLE);
      ringing   <= (state_n == ST_RING);
      remaining <= remaining_n;
      ring_cnt  <= ring_cnt_n;
    end
  end

`ifdef NAP_TIMER_SNOOZE_EN
  // Snoozes used during the current nap.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      snooze_cnt <= '0;
    end else begin
      snooze_cnt <= snooze_n;
    end
  end
`else
  assign snooze_cnt = '0;
`endif

endmodule

// File: tb/tb_nap_timer.sv
// Directed self-checking bench for nap_timer (both default and snooze builds).
module tb_nap_timer;

  logic       reset;
  logic       clock;
  logic       tick;
  logic       arm;
  logic       cancel;
  logic       button;
  logic [7:0] nap_len;
  logic       start;
  logic       stop;
  logic       busy;
  logic       ringing;
  logic [7:0] remaining;
  logic [1:0] snooze_cnt;

  int n_total = 0;
  int n_bad   = 0;
  int n_start = 0;
  int n_stop  = 0;
  int n_both  = 0;
  int s0;
  int t0;

  nap_timer dut (
    .reset     (reset),
    .clock     (clock),
    .tick      (tick),
    .arm       (arm),
    .cancel    (cancel),
    .button    (button),
    .nap_len   (nap_len),
    .start     (start),
    .stop      (stop),
    .busy      (busy),
    .ringing   (ringing),
    .remaining (remaining),
    .snooze_cnt(snooze_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Pulse bookkeeping, sampled away from the active edge.
  always @(negedge clock) begin
    if (start) n_start++;
    if (stop) n_stop++;
    if (start && stop) n_both++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_tick();
    tick = 1'b1;
    @(negedge clock);
    tick = 1'b0;
  endtask

  task automatic do_arm(input logic [7:0] len);
    arm     = 1'b1;
    nap_len = len;
    @(negedge clock);
    arm = 1'b0;
  endtask

  task automatic press(input int hold);
    button = 1'b1;
    repeat (hold) @(negedge clock);
    button = 1'b0;
    repeat (10) @(negedge clock);
  endtask

  initial begin
    reset = 1'b0; tick = 1'b0; arm = 1'b0; cancel = 1'b0; button = 1'b0; nap_len = 8'd0;
    #1;
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_start_stop", 32'({start, stop, ringing}), 0);
    check_eq("rst_remaining", 32'(remaining), 0);
    step(2);
    reset = 1'b1;
    step(2);

    // Basic countdown of 3 ticks, ticks every 10 clocks.
    s0 = n_start;
    do_arm(8'd3);
    check_eq("cnt_load", 32'(remaining), 3);
    check_eq("cnt_busy", 32'(busy), 1);
    check_eq("cnt_snooze_clr", 32'(snooze_cnt), 0);
    step(9);
    do_tick();
    check_eq("cnt_r2", 32'(remaining), 2);
    check_eq("cnt_no_start", 32'(start), 0);
    step(9);
    do_tick();
    check_eq("cnt_r1", 32'(remaining), 1);
    step(9);
    do_tick();
    check_eq("cnt_r0", 32'(remaining), 0);
    check_eq("cnt_start", 32'(start), 1);
    check_eq("cnt_ringing", 32'(ringing), 1);
    step(2);
    check_eq("cnt_start_once", 32'(n_start - s0), 1);

    // Arm while busy is ignored.
    s0 = n_start;
    do_arm(8'd9);
    step(1);
    check_eq("arm_busy_ring", 32'(ringing), 1);
    check_eq("arm_busy_rem", 32'(remaining), 0);
    check_eq("arm_busy_start", 32'(n_start - s0), 0);

    // Short button glitch does not stop the ring.
    s0 = n_stop;
    press(2);
    check_eq("glitch_stop", 32'(n_stop - s0), 0);
    check_eq("glitch_ring", 32'(ringing), 1);

    // Long press: one stop pulse; dismiss by default, snooze when enabled.
    press(6);
    check_eq("press_stop", 32'(n_stop - s0), 1);
`ifdef NAP_TIMER_SNOOZE_EN
    check_eq("press_snooze_busy", 32'(busy), 1);
    check_eq("press_snooze_rem", 32'(remaining), 5);
    check_eq("press_snooze_cnt", 32'(snooze_cnt), 1);
    cancel = 1'b1;
    step(1);
    cancel = 1'b0;
    step(1);
`endif
    check_eq("press_idle", 32'(busy), 0);

    // Zero-length nap rings immediately, then times out on the 60th tick.
    s0 = n_start;
    t0 = n_stop;
    do_arm(8'd0);
    check_eq("zero_start", 32'(start), 1);
    check_eq("zero_ring", 32'(ringing), 1);
    for (int i = 1; i < 60; i++) begin
      do_tick();
      step(1);
    end
    check_eq("to_59_stop", 32'(n_stop - t0), 0);
    check_eq("to_59_ring", 32'(ringing), 1);
    do_tick();
    check_eq("to_60_stop", 32'(stop), 1);
    check_eq("to_60_busy", 32'(busy), 0);
    step(2);
    check_eq("to_stop_once", 32'(n_stop - t0), 1);
    check_eq("to_start_once", 32'(n_start - s0), 1);

    // Cancel coincident with a tick at remaining==2.
    do_arm(8'd4);
    do_tick();
    do_tick();
    check_eq("cx_rem2", 32'(remaining), 2);
    s0 = n_start;
    t0 = n_stop;
    tick = 1'b1;
    cancel = 1'b1;
    step(1);
    tick = 1'b0;
    cancel = 1'b0;
    check_eq("cx_rem0", 32'(remaining), 0);
    check_eq("cx_busy", 32'(busy), 0);
    step(3);
    check_eq("cx_pulses", 32'((n_start - s0) + (n_stop - t0)), 0);

    // Cancel coincident with a debounced press in RING: a single stop, IDLE.
    do_arm(8'd0);
    step(1);
    t0 = n_stop;
    button = 1'b1;
    step(6);
    cancel = 1'b1;
    step(1);
    cancel = 1'b0;
    button = 1'b0;
    check_eq("cb_busy", 32'(busy), 0);
    step(10);
    check_eq("cb_stop_once", 32'(n_stop - t0), 1);
    check_eq("cb_still_idle", 32'(busy), 0);

`ifdef NAP_TIMER_SNOOZE_EN
    // Three snoozes then a dismissing fourth press.
    do_arm(8'd2);
    do_tick();
    do_tick();
    check_eq("sz_ring", 32'(ringing), 1);
    check_eq("sz_cnt0", 32'(snooze_cnt), 0);
    for (int k = 1; k <= 3; k++) begin
      s0 = n_start;
      t0 = n_stop;
      press(6);
      check_eq("sz_stop", 32'(n_stop - t0), 1);
      check_eq("sz_cnt", 32'(snooze_cnt), 32'(k));
      check_eq("sz_rem", 32'(remaining), 5);
      check_eq("sz_count_state", 32'({busy, ringing}), 2);
      for (int j = 0; j < 4; j++) begin
        do_tick();
        step(1);
      end
      check_eq("sz_rem1", 32'(remaining), 1);
      do_tick();
      check_eq("sz_start", 32'(start), 1);
      check_eq("sz_ring_again", 32'(ringing), 1);
      step(2);
      check_eq("sz_start_once", 32'(n_start - s0), 1);
    end
    t0 = n_stop;
    press(6);
    check_eq("sz4_stop", 32'(n_stop - t0), 1);
    check_eq("sz4_idle", 32'(busy), 0);
    check_eq("sz4_cnt", 32'(snooze_cnt), 3);
`endif

    // Reset mid-count with remaining==7 clears everything without pulses.
    do_arm(8'd9);
    do_tick();
    do_tick();
    check_eq("mr_rem7", 32'(remaining), 7);
    s0 = n_start;
    t0 = n_stop;
    reset = 1'b0;
    #1;
    check_eq("mr_async", 32'({start, stop, busy, ringing}), 0);
    check_eq("mr_rem", 32'(remaining), 0);
    check_eq("mr_snooze", 32'(snooze_cnt), 0);
    step(3);
    reset = 1'b1;
    step(2);
    check_eq("mr_no_pulse", 32'((n_start - s0) + (n_stop - t0)), 0);
    do_arm(8'd4);
    check_eq("mr_rearm_rem", 32'(remaining), 4);
    check_eq("mr_rearm_busy", 32'({busy, ringing}), 2);

    step(2);
    check_eq("start_stop_overlap", 32'(n_both), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
